// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry / add-subtract unit.
package calc_pkg;

    localparam int unsigned CALC_DIG_W = 4;

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_EXEC,
        S_RES
    } calc_state_t;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } calc_op_t;

endpackage

// File: rtl/calc_entry_reg.sv
// Hex-digit shift register with a saturating digit counter.
// Priority: clear > load > shift. Shift may combine with clear/load (applied on the cleared value).
module calc_entry_reg
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       load_i,
    input  logic [CALC_DIG_W*NDIG-1:0] load_val_i,
    input  logic                       shift_i,
    input  logic [CALC_DIG_W-1:0]      digit_i,
    output logic [CALC_DIG_W*NDIG-1:0] value_o,
    output logic [CALC_DIG_W*NDIG-1:0] value_next_o
);

    localparam int unsigned W    = CALC_DIG_W * NDIG;
    localparam int unsigned CntW = $clog2(NDIG + 1);

    logic [W-1:0]            value_q, value_d, base_val;
    logic [CntW-1:0]         cnt_q, cnt_d, base_cnt;
    logic [W+CALC_DIG_W-1:0] shifted;

    always_comb begin
        base_val = value_q;
        base_cnt = cnt_q;
        if (clr_i) begin
            base_val = '0;
            base_cnt = '0;
        end else if (load_i) begin
            base_val = load_val_i;
            base_cnt = '0;
        end
        shifted = {base_val, digit_i};
        value_d = base_val;
        cnt_d   = base_cnt;
        // Digits beyond NDIG are dropped without any indication.
        if (shift_i && (base_cnt < CntW'(NDIG))) begin
            value_d = shifted[W-1:0];
            cnt_d   = base_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value_o      = value_q;
    assign value_next_o = value_d;

endmodule

// File: rtl/calc_entry_alu.sv
// Operand entry FSM, add/subtract ALU and registered display outputs.
// Define CALC_SAT_EN for saturating results; otherwise results wrap modulo 2^W.
module calc_entry_alu
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       key_valid,
    input  logic [CALC_DIG_W-1:0]      key_code,
    input  logic                       op_add,
    input  logic                       op_sub,
    input  logic                       eq,
    output logic [CALC_DIG_W*NDIG-1:0] disp,
    output logic                       res_valid,
    output logic                       carry,
    output logic                       err
);

    localparam int unsigned W = CALC_DIG_W * NDIG;

    calc_state_t state_q, state_d;
    calc_op_t    op_q, op_d;
    logic [W-1:0] res_q, res_d, disp_q, disp_d;
    logic         carry_q, carry_d, res_valid_q, res_valid_d, err_q, err_d;

    logic         a_clr, a_load, a_shift, b_clr, b_shift;
    logic [W-1:0] a_val, a_next, b_val, b_next;
    logic [W:0]   sum_w, diff_w;
    logic [W-1:0] alu_res;
    logic         alu_carry;

    calc_entry_reg #(.NDIG(NDIG)) u_reg_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (a_clr),
        .load_i       (a_load),
        .load_val_i   (res_q),
        .shift_i      (a_shift),
        .digit_i      (key_code),
        .value_o      (a_val),
        .value_next_o (a_next)
    );

    calc_entry_reg #(.NDIG(NDIG)) u_reg_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (b_clr),
        .load_i       (1'b0),
        .load_val_i   ('0),
        .shift_i      (b_shift),
        .digit_i      (key_code),
        .value_o      (b_val),
        .value_next_o (b_next)
    );

    assign sum_w  = {1'b0, a_val} + {1'b0, b_val};
    assign diff_w = {1'b0, a_val} - {1'b0, b_val};

    always_comb begin
        if (op_q == OP_ADD) begin
            alu_carry = sum_w[W];
            alu_res   = sum_w[W-1:0];
        end else begin
            alu_carry = diff_w[W];  // borrow out equals A < B
            alu_res   = diff_w[W-1:0];
        end
`ifdef CALC_SAT_EN
        if (alu_carry) begin
            alu_res = (op_q == OP_ADD) ? '1 : '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        carry_d     = carry_q;
        res_valid_d = res_valid_q;
        err_d       = 1'b0;
        a_clr       = 1'b0;
        a_load      = 1'b0;
        a_shift     = 1'b0;
        b_clr       = 1'b0;
        b_shift     = 1'b0;
        if (clr) begin
            state_d     = S_A;
            op_d        = OP_ADD;
            res_d       = '0;
            carry_d     = 1'b0;
            res_valid_d = 1'b0;
            a_clr       = 1'b1;
            b_clr       = 1'b1;
        end else begin
            unique case (state_q)
                S_A: begin
                    if (eq) begin
                        err_d = 1'b1;
                    end else if (op_add || op_sub) begin
                        op_d    = op_add ? OP_ADD : OP_SUB;
                        b_clr   = 1'b1;
                        state_d = S_B;
                    end else if (key_valid) begin
                        a_shift = 1'b1;
                    end
                end
                S_B: begin
                    if (eq) begin
                        state_d = S_EXEC;
                    end else if (op_add || op_sub) begin
                        op_d = op_add ? OP_ADD : OP_SUB;
                    end else if (key_valid) begin
                        b_shift = 1'b1;
                    end
                end
                S_EXEC: begin
                    err_d       = eq || op_add || op_sub;
                    res_d       = alu_res;
                    carry_d     = alu_carry;
                    res_valid_d = 1'b1;
                    state_d     = S_RES;
                end
                S_RES: begin
                    if (eq) begin
                        err_d = 1'b1;
                    end else if (op_add || op_sub) begin
                        a_load      = 1'b1;
                        op_d        = op_add ? OP_ADD : OP_SUB;
                        b_clr       = 1'b1;
                        res_valid_d = 1'b0;
                        state_d     = S_B;
                    end else if (key_valid) begin
                        a_clr       = 1'b1;
                        a_shift     = 1'b1;
                        res_valid_d = 1'b0;
                        state_d     = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // Display follows the state being entered so it updates in the same cycle as the data.
    always_comb begin
        disp_d = disp_q;
        unique case (state_d)
            S_A:     disp_d = a_next;
            S_B:     disp_d = b_next;
            S_EXEC:  disp_d = disp_q;
            S_RES:   disp_d = res_d;
            default: disp_d = disp_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            op_q        <= OP_ADD;
            res_q       <= '0;
            disp_q      <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            disp_q      <= disp_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign disp      = disp_q;
    assign res_valid = res_valid_q;
    assign carry     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_entry_alu.sv
// Directed self-checking bench for calc_entry_alu with NDIG = 2.
module tb_calc_entry_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       op_add = 1'b0;
    logic       op_sub = 1'b0;
    logic       eq = 1'b0;
    logic [7:0] disp;
    logic       res_valid;
    logic       carry;
    logic       err;

    int checks = 0;
    int failures = 0;

    calc_entry_alu #(.NDIG(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_add    (op_add),
        .op_sub    (op_sub),
        .eq        (eq),
        .disp      (disp),
        .res_valid (res_valid),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic strobe(input logic s_clr, input logic s_eq, input logic s_add,
                          input logic s_sub);
        clr    = s_clr;
        eq     = s_eq;
        op_add = s_add;
        op_sub = s_sub;
        tick();
        clr    = 1'b0;
        eq     = 1'b0;
        op_add = 1'b0;
        op_sub = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("rst_disp", disp, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // 0x12 + 0x34
        press(4'h1);
        check_eq("key1_disp", disp, 8'h01);
        press(4'h2);
        check_eq("key2_disp", disp, 8'h12);
        strobe(0, 0, 1, 0);
        check_eq("opadd_disp_b", disp, 8'h00);
        press(4'h3);
        press(4'h4);
        check_eq("b_disp", disp, 8'h34);
        strobe(0, 1, 0, 0);
        check_eq("exec_hold_disp", disp, 8'h34);
        check_eq("exec_res_valid", res_valid, 0);
        tick();
        check_eq("add_disp", disp, 8'h46);
        check_eq("add_res_valid", res_valid, 1);
        check_eq("add_carry", carry, 0);

        // Chain: 0x46 + 0x01
        strobe(0, 0, 1, 0);
        check_eq("chain_res_valid_drop", res_valid, 0);
        press(4'h0);
        press(4'h1);
        strobe(0, 1, 0, 0);
        tick();
        check_eq("chain_disp", disp, 8'h47);
        check_eq("chain_res_valid", res_valid, 1);

        // clr beats eq in the same cycle
        strobe(1, 1, 0, 0);
        check_eq("clr_disp", disp, 0);
        check_eq("clr_res_valid", res_valid, 0);
        check_eq("clr_err", err, 0);

        // 0xFF + 0x02
        press(4'hF);
        press(4'hF);
        strobe(0, 0, 1, 0);
        press(4'h0);
        press(4'h2);
        strobe(0, 1, 0, 0);
        tick();
`ifdef CALC_SAT_EN
        check_eq("ovf_disp", disp, 8'hFF);
`else
        check_eq("ovf_disp", disp, 8'h01);
`endif
        check_eq("ovf_carry", carry, 1);

        // Key from S_RES restarts A: 0x05 - 0x09
        press(4'h0);
        check_eq("res_key_disp", disp, 8'h00);
        check_eq("res_key_res_valid", res_valid, 0);
        press(4'h5);
        check_eq("a05_disp", disp, 8'h05);
        strobe(0, 0, 0, 1);
        press(4'h0);
        press(4'h9);
        strobe(0, 1, 0, 0);
        tick();
`ifdef CALC_SAT_EN
        check_eq("sub_disp", disp, 8'h00);
`else
        check_eq("sub_disp", disp, 8'hFC);
`endif
        check_eq("sub_carry", carry, 1);

        // Third digit ignored, eq in S_A is an error
        strobe(1, 0, 0, 0);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check_eq("sat_cnt_disp", disp, 8'h12);
        strobe(0, 1, 0, 0);
        check_eq("sa_eq_err", err, 1);
        check_eq("sa_eq_disp", disp, 8'h12);
        tick();
        check_eq("sa_err_pulse_end", err, 0);
        strobe(0, 1, 0, 0);
        check_eq("sa_still_err", err, 1);

        // Op strobe during S_EXEC flags error but result still lands
        strobe(1, 0, 0, 0);
        press(4'h2);
        strobe(0, 0, 1, 0);
        press(4'h3);
        strobe(0, 1, 0, 0);
        strobe(0, 0, 1, 0);
        check_eq("exec_op_err", err, 1);
        check_eq("exec_op_disp", disp, 8'h05);
        tick();
        check_eq("exec_err_end", err, 0);

        // Async reset during S_EXEC
        strobe(1, 0, 0, 0);
        press(4'h1);
        strobe(0, 0, 1, 0);
        press(4'h1);
        strobe(0, 1, 0, 0);
        check_eq("pre_rst_disp", disp, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_disp", disp, 0);
        check_eq("arst_res_valid", res_valid, 0);
        check_eq("arst_carry", carry, 0);
        check_eq("arst_err", err, 0);
        #1 rst_n = 1'b1;
        tick();
        press(4'h0);
        press(4'h7);
        check_eq("post_rst_disp", disp, 8'h07);
        check_eq("post_rst_res_valid", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
